// File: rtl/pri_dec_tracker_if.sv
// Request/status bundle for the index-to-bitmap occupancy tracker.
// master drives set/clear requests; slave is the tracker itself.
interface pri_dec_tracker_if #(
   parameter int WIDTH     = 16,
   parameter int LOG_WIDTH = 4
);
   logic                 set_valid;
   logic                 set_ready;
   logic [LOG_WIDTH-1:0] set_idx;
   logic                 clr_valid;
   logic [LOG_WIDTH-1:0] clr_idx;
   logic [WIDTH-1:0]     dec_out;
   logic                 dec_valid;
   logic [WIDTH-1:0]     bitmap;
   logic [LOG_WIDTH:0]   count;
   logic                 full;
   logic                 empty;
   logic                 err_set;
   logic                 err_clr;

   modport master (
      output set_valid, set_idx, clr_valid, clr_idx,
      input  set_ready, dec_out, dec_valid, bitmap, count, full, empty,
             err_set, err_clr
   );

   modport slave (
      input  set_valid, set_idx, clr_valid, clr_idx,
      output set_ready, dec_out, dec_valid, bitmap, count, full, empty,
             err_set, err_clr
   );
endinterface

// File: rtl/pri_dec_tracker.sv
// Occupancy tracker: decodes set/clear indices to one-hot and marks entries
// busy/free in a registered bitmap, with popcount, full/empty and error pulses.
module pri_dec_tracker_cell (
   input  logic clk,
   input  logic rst,
   input  logic clr_hit,
   input  logic set_hit,
   output logic busy
);
   // clear lands before set, so a same-cycle clear+set leaves the entry busy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) busy <= 1'b0;
      else      busy <= set_hit | (busy & ~clr_hit);
   end
endmodule

module pri_dec_tracker #(
   parameter int WIDTH     = 16,
   parameter int LOG_WIDTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   pri_dec_tracker_if.slave  bus
);
   localparam logic [LOG_WIDTH:0] FULL_CNT = (LOG_WIDTH+1)'(WIDTH);

   // all-zero for indices >= WIDTH, which folds the range check into the decode
   function automatic logic [WIDTH-1:0] onehot(input logic [LOG_WIDTH-1:0] idx);
      logic [WIDTH-1:0] oh;
      for (int i = 0; i < WIDTH; i++) oh[i] = (idx == LOG_WIDTH'(i));
      return oh;
   endfunction

   logic [WIDTH-1:0]   bitmap;
   logic [LOG_WIDTH:0] count;
   logic [WIDTH-1:0]   dec_out;
   logic               dec_valid, err_set, err_clr;

   logic               full, set_acc, clr_eff, set_eff;
   logic [WIDTH-1:0]   clr_oh, set_oh, mid;

   assign full    = (count == FULL_CNT);
   assign set_acc = bus.set_valid & ~full;

   assign clr_oh  = onehot(bus.clr_idx);
   assign set_oh  = onehot(bus.set_idx);
   assign clr_eff = bus.clr_valid & |(bitmap & clr_oh);
   assign mid     = bitmap & ~(clr_eff ? clr_oh : '0);
   assign set_eff = set_acc & |set_oh & ~|(mid & set_oh);

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      pri_dec_tracker_cell u_cell (
         .clk     (clk),
         .rst     (rst),
         .clr_hit (clr_eff & clr_oh[i]),
         .set_hit (set_eff & set_oh[i]),
         .busy    (bitmap[i])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count     <= '0;
         dec_out   <= '0;
         dec_valid <= 1'b0;
         err_set   <= 1'b0;
         err_clr   <= 1'b0;
      end else begin
         case ({set_eff, clr_eff})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (set_eff) dec_out <= set_oh;
         dec_valid <= set_eff;
         err_set   <= set_acc & ~set_eff;
         err_clr   <= bus.clr_valid & ~clr_eff;
      end
   end

   assign bus.set_ready = ~full;
   assign bus.full      = full;
   assign bus.empty     = (count == '0);
   assign bus.bitmap    = bitmap;
   assign bus.count     = count;
   assign bus.dec_out   = dec_out;
   assign bus.dec_valid = dec_valid;
   assign bus.err_set   = err_set;
   assign bus.err_clr   = err_clr;
endmodule

// File: tb/tb_pri_dec_tracker.sv
// Directed-vector bench for pri_dec_tracker: a 16-entry instance driven from a
// vector table, and a 12-entry instance for range and async-reset cases.
module tb_pri_dec_tracker;
   logic clk = 1'b0;
   logic rst_a, rst_b;
   always #5 clk = ~clk;

   pri_dec_tracker_if #(.WIDTH(16), .LOG_WIDTH(4)) bus_a ();
   pri_dec_tracker_if #(.WIDTH(12), .LOG_WIDTH(4)) bus_b ();

   pri_dec_tracker #(.WIDTH(16), .LOG_WIDTH(4)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a.slave));
   pri_dec_tracker #(.WIDTH(12), .LOG_WIDTH(4)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b.slave));

   typedef struct {
      logic        sv;
      logic [3:0]  si;
      logic        cv;
      logic [3:0]  ci;
      logic [15:0] bm;
      logic [4:0]  cnt;
      logic        dv;
      logic [15:0] dout;
      logic        es;
      logic        ec;
   } vec_t;

   vec_t tbl[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic sv, input int si, input logic cv, input int ci,
                      input logic [15:0] bm, input int cnt, input logic dv,
                      input logic [15:0] dout, input logic es, input logic ec);
      vec_t v;
      v.sv = sv; v.si = 4'(si); v.cv = cv; v.ci = 4'(ci);
      v.bm = bm; v.cnt = 5'(cnt); v.dv = dv; v.dout = dout; v.es = es; v.ec = ec;
      tbl.push_back(v);
   endtask

   task automatic chk_b(input string tag, input logic [11:0] bm, input int cnt,
                        input logic dv, input logic es, input logic ec);
      n_vec++;
      chk({tag, ".bitmap"},    32'(bus_b.bitmap),    32'(bm));
      chk({tag, ".count"},     32'(bus_b.count),     32'(cnt));
      chk({tag, ".dec_valid"}, 32'(bus_b.dec_valid), 32'(dv));
      chk({tag, ".err_set"},   32'(bus_b.err_set),   32'(es));
      chk({tag, ".err_clr"},   32'(bus_b.err_clr),   32'(ec));
      chk({tag, ".empty"},     32'(bus_b.empty),     32'(cnt == 0));
   endtask

   task automatic step_b(input logic sv, input int si, input logic cv, input int ci);
      bus_b.set_valid = sv; bus_b.set_idx = 4'(si);
      bus_b.clr_valid = cv; bus_b.clr_idx = 4'(ci);
      @(posedge clk); #1;
      bus_b.set_valid = 1'b0; bus_b.clr_valid = 1'b0;
   endtask

   initial begin
      logic [15:0] bm;
      int          cnt;
      string       tag;

      // ---- vector table for the 16-entry instance ----
      add(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0);
      add(1, 3, 0, 0, 16'h0008, 1, 1, 16'h0008, 0, 0);
      add(0, 0, 0, 0, 16'h0008, 1, 0, 16'h0008, 0, 0);
      add(1, 3, 0, 0, 16'h0008, 1, 0, 16'h0008, 1, 0);
      add(0, 0, 0, 0, 16'h0008, 1, 0, 16'h0008, 0, 0);
      for (int i = 0; i < 16; i++) begin
         bm = 16'h0008 | 16'((32'h1 << (i + 1)) - 1);
         add(1, i, 0, 0, bm, (i < 3) ? i + 2 : i + 1, i != 3,
             (i == 3) ? 16'h0004 : 16'(32'h1 << i), i == 3, 0);
      end
      add(1, 5, 0, 0, 16'hFFFF, 16, 0, 16'h8000, 0, 0);
      add(1, 7, 1, 7, 16'hFF7F, 15, 0, 16'h8000, 0, 0);
      add(1, 7, 0, 0, 16'hFFFF, 16, 1, 16'h0080, 0, 0);
      bm = 16'hFFFF; cnt = 16;
      for (int i = 0; i < 16; i++) begin
         if (i == 4) continue;
         bm = bm & ~16'(32'h1 << i);
         cnt--;
         add(0, 0, 1, i, bm, cnt, 0, 16'h0080, 0, 0);
      end
      add(1, 4, 1, 4, 16'h0010, 1, 1, 16'h0010, 0, 0);
      add(0, 0, 1, 9, 16'h0010, 1, 0, 16'h0010, 0, 1);
      add(1, 5, 1, 5, 16'h0030, 2, 1, 16'h0020, 0, 1);
      add(0, 0, 1, 4, 16'h0020, 1, 0, 16'h0020, 0, 0);

      bus_a.set_valid = 0; bus_a.set_idx = 0; bus_a.clr_valid = 0; bus_a.clr_idx = 0;
      bus_b.set_valid = 0; bus_b.set_idx = 0; bus_b.clr_valid = 0; bus_b.clr_idx = 0;
      rst_a = 0; rst_b = 0;
      #12;
      n_vec++;
      chk("rst.bitmap",    32'(bus_a.bitmap),    0);
      chk("rst.count",     32'(bus_a.count),     0);
      chk("rst.dec_out",   32'(bus_a.dec_out),   0);
      chk("rst.dec_valid", 32'(bus_a.dec_valid), 0);
      chk("rst.err",       32'({bus_a.err_set, bus_a.err_clr}), 0);
      chk("rst.empty",     32'(bus_a.empty),     1);
      chk("rst.full",      32'(bus_a.full),      0);
      chk("rst.set_ready", 32'(bus_a.set_ready), 1);
      @(posedge clk); #1;
      rst_a = 1; rst_b = 1;

      foreach (tbl[k]) begin
         bus_a.set_valid = tbl[k].sv; bus_a.set_idx = tbl[k].si;
         bus_a.clr_valid = tbl[k].cv; bus_a.clr_idx = tbl[k].ci;
         @(posedge clk); #1;
         n_vec++;
         tag = $sformatf("v%0d", k);
         chk({tag, ".bitmap"},    32'(bus_a.bitmap),    32'(tbl[k].bm));
         chk({tag, ".count"},     32'(bus_a.count),     32'(tbl[k].cnt));
         chk({tag, ".dec_valid"}, 32'(bus_a.dec_valid), 32'(tbl[k].dv));
         chk({tag, ".dec_out"},   32'(bus_a.dec_out),   32'(tbl[k].dout));
         chk({tag, ".err_set"},   32'(bus_a.err_set),   32'(tbl[k].es));
         chk({tag, ".err_clr"},   32'(bus_a.err_clr),   32'(tbl[k].ec));
         chk({tag, ".full"},      32'(bus_a.full),      32'(tbl[k].cnt == 16));
         chk({tag, ".empty"},     32'(bus_a.empty),     32'(tbl[k].cnt == 0));
         chk({tag, ".set_ready"}, 32'(bus_a.set_ready), 32'(tbl[k].cnt != 16));
      end
      bus_a.set_valid = 0; bus_a.clr_valid = 0;

      // ---- 12-entry instance: out-of-range indices and async reset ----
      step_b(1, 13, 0, 0);  chk_b("b.set13", 12'h000, 0, 0, 1, 0);
      step_b(1, 12, 0, 0);  chk_b("b.set12", 12'h000, 0, 0, 1, 0);
      step_b(1, 0, 0, 0);   chk_b("b.set0",  12'h001, 1, 1, 0, 0);
      step_b(1, 2, 0, 0);   chk_b("b.set2",  12'h005, 2, 1, 0, 0);
      step_b(1, 5, 0, 0);   chk_b("b.set5",  12'h025, 3, 1, 0, 0);
      step_b(1, 7, 0, 0);   chk_b("b.set7",  12'h0A5, 4, 1, 0, 0);
      step_b(0, 0, 1, 11);  chk_b("b.clr11", 12'h0A5, 4, 0, 0, 1);
      step_b(0, 0, 1, 14);  chk_b("b.clr14", 12'h0A5, 4, 0, 0, 1);
      step_b(1, 11, 0, 0);  chk_b("b.set11", 12'h8A5, 5, 1, 0, 0);
      n_vec++;
      chk("b.set11.dec_out", 32'(bus_b.dec_out), 32'h800);
      step_b(0, 0, 1, 11);  chk_b("b.clr11b", 12'h0A5, 4, 0, 0, 0);

      // reset lands mid-cycle with a set pending; must clear immediately
      bus_b.set_valid = 1; bus_b.set_idx = 4'd9;
      #2 rst_b = 0;
      #1 chk_b("b.async_rst", 12'h000, 0, 0, 0, 0);
      bus_b.set_valid = 0;
      @(posedge clk); #3;
      rst_b = 1;
      @(posedge clk); #1;
      chk_b("b.post_rst", 12'h000, 0, 0, 0, 0);
      @(posedge clk); #1;
      chk_b("b.post_rst2", 12'h000, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
